// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter sequencer with branch, call/return through a
//             circular return-address stack (RAS), and a terminal HALT state.
//  Ports    : clk, rst (async, active-high)
//             i_en        advance enable (low = stall)
//             i_br_taken  jump to i_br_target
//             i_br_target branch / call target
//             i_call      push pc+INCR, jump to i_br_target
//             i_ret       pop RAS top, jump to it
//             i_halt      enter HALT
//             o_pc        registered instruction address
//             o_halted    high in HALT
//             o_ras_empty / o_ras_full  occupancy flags
//             o_ras_ovf / o_ras_unf     sticky overflow / underflow flags
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int unsigned              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]        RESET_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned              INCR       = 1,
    parameter int unsigned              RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_ras_empty,
    output logic              o_ras_full,
    output logic              o_ras_ovf,
    output logic              o_ras_unf
);

    localparam int unsigned C_CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned C_PTR_W = $clog2(RAS_DEPTH);
    localparam logic [C_PTR_W-1:0] C_LAST = C_PTR_W'(RAS_DEPTH - 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(RAS_DEPTH);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_next;
    logic [C_CNT_W-1:0]  r_count, w_count_next;
    logic [C_PTR_W-1:0]  r_top, w_top_next;
    logic                r_ovf, w_ovf_next;
    logic                r_unf, w_unf_next;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];

    logic                w_wr_en;
    logic [C_PTR_W-1:0]  w_wr_idx;
    logic [ADDR_W-1:0]   w_seq;
    logic [C_PTR_W-1:0]  w_top_inc;
    logic [C_PTR_W-1:0]  w_top_dec;
    logic                w_empty;
    logic                w_full;

    assign w_seq     = r_pc + ADDR_W'(INCR);
    // Pointer arithmetic wraps at RAS_DEPTH, which need not be a power of two
    assign w_top_inc = (r_top == C_LAST) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? C_LAST : r_top - 1'b1;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);

    // State / control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_ADDR;
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_top   <= w_top_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Stack entries carry no reset; only count/pointer/flags define validity
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_ras[w_wr_idx] <= w_seq;
        end
    end

    // Next-state / next-value logic
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_count_next = r_count;
        w_top_next   = r_top;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_top;

        if (r_state == S_RUN && i_en) begin
            if (i_halt) begin
                w_state_next = S_HALT;
            end else if (i_ret && !w_empty && i_call) begin
                // Swap: return to top, replace top with this call's return address
                w_pc_next = r_ras[r_top];
                w_wr_en   = 1'b1;
                w_wr_idx  = r_top;
            end else if (i_ret && !w_empty) begin
                w_pc_next    = r_ras[r_top];
                w_top_next   = w_top_dec;
                w_count_next = r_count - 1'b1;
            end else if (i_ret && !i_call) begin
                w_pc_next  = w_seq;
                w_unf_next = 1'b1;
            end else if (i_call) begin
                // Reaching here with i_ret set means the stack was empty
                if (i_ret) begin
                    w_unf_next = 1'b1;
                end
                w_pc_next  = i_br_target;
                w_wr_en    = 1'b1;
                w_wr_idx   = w_top_inc;
                w_top_next = w_top_inc;
                // A push on a full stack lands on the oldest slot
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end else if (i_br_taken) begin
                w_pc_next = i_br_target;
            end else begin
                w_pc_next = w_seq;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_halted    = (r_state == S_HALT);
    assign o_ras_empty = w_empty;
    assign o_ras_full  = w_full;
    assign o_ras_ovf   = r_ovf;
    assign o_ras_unf   = r_unf;

endmodule
`default_nettype wire
